// File: rtl/alu32_arbiter.sv
// rtl/alu32_arbiter.sv - round-robin arbiter sharing one alu32 between two requesters
module alu32_arbiter #(
    parameter int W   = 32,
    parameter int OPW = 3,
    parameter int CW  = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    input  logic [OPW-1:0] req0_op,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    input  logic [OPW-1:0] req1_op,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [W-1:0]   alu_result,
    input  logic           alu_c,
    input  logic           alu_n,
    input  logic           alu_z,
    input  logic           alu_v,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [W-1:0]   rsp_result,
    output logic [3:0]     rsp_flags,
    output logic [CW-1:0]  ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   grant_any;
    logic   grant_id;

    // Pick a winner while idle: a lone requester wins, a tie goes to whoever was not served last
    always_comb begin
        grant_any = (state == IDLE) && (req0_valid || req1_valid);
        grant_id  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    end

    assign req0_ready = grant_any && !grant_id;
    assign req1_ready = grant_any &&  grant_id;

    // Operation sequencer: latch operands on accept, capture the ALU one cycle later, hold the response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            ops_done   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        alu_a      <= grant_id ? req1_a  : req0_a;
                        alu_b      <= grant_id ? req1_b  : req0_b;
                        alu_op     <= grant_id ? req1_op : req0_op;
                        rsp_id     <= grant_id;
                        last_grant <= grant_id;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_flags  <= {alu_c, alu_n, alu_z, alu_v};
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ops_done  <= ops_done + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu32_arbiter.sv
// tb/tb_alu32_arbiter.sv - scoreboard bench for alu32_arbiter with a behavioural alu32
module tb_alu32_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]  req0_op = '0, req1_op = '0;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_op;
    logic        alu_c, alu_n, alu_z, alu_v;
    logic        rsp_valid, rsp_id;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [15:0] ops_done;

    typedef struct packed {
        logic        id;
        logic [31:0] result;
        logic [3:0]  flags;
    } exp_t;

    exp_t exp_q[$];
    logic grant_log[$];
    int   checks = 0;
    int   errors = 0;
    int   dual_ready_errs = 0;

    always #5 clk = ~clk;

    alu32_arbiter #(.W(32), .OPW(3), .CW(16)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result),
        .alu_c(alu_c), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .ops_done(ops_done)
    );

    // Behavioural alu32: add, sub, and, or, xor, sll, srl, slt
    always_comb begin
        logic [32:0] wide;
        wide       = '0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        alu_result = '0;
        case (alu_op)
            3'd0: begin
                wide = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = wide[31:0];
                alu_c = wide[32];
                alu_v = (alu_a[31] == alu_b[31]) && (wide[31] != alu_a[31]);
            end
            3'd1: begin
                wide = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                alu_result = wide[31:0];
                alu_c = wide[32];
                alu_v = (alu_a[31] != alu_b[31]) && (wide[31] != alu_a[31]);
            end
            3'd2: alu_result = alu_a & alu_b;
            3'd3: alu_result = alu_a | alu_b;
            3'd4: alu_result = alu_a ^ alu_b;
            3'd5: alu_result = alu_a << alu_b[4:0];
            3'd6: alu_result = alu_a >> alu_b[4:0];
            default: alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
        endcase
        alu_n = alu_result[31];
        alu_z = (alu_result == 32'd0);
    end

    // Monitor: every consumed response is checked against the head of the scoreboard
    always @(negedge clk) begin
        #2;
        if (!reset) begin
            if (req0_ready && req1_ready) dual_ready_errs++;
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got id=%0d result=%h flags=%b, required no response", rsp_id, rsp_result, rsp_flags);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (rsp_id !== e.id || rsp_result !== e.result || rsp_flags !== e.flags) begin
                        errors++;
                        $display("FAIL rsp_compare: got id=%0d result=%h flags=%b, required id=%0d result=%h flags=%b",
                                 rsp_id, rsp_result, rsp_flags, e.id, e.result, e.flags);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic drive(input logic id, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        if (id == 1'b0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    // Present one operation, wait for its grant, and push the hand-computed response
    task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic [31:0] er, input logic [3:0] ef);
        bit got = 0;
        @(negedge clk);
        drive(id, 1'b1, a, b, op);
        for (int n = 0; n < 50; n++) begin
            #1;
            if ((id == 1'b0) ? req0_ready : req1_ready) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        if (got) begin
            exp_q.push_back('{id: id, result: er, flags: ef});
            grant_log.push_back(id);
            @(posedge clk);
            #1;
        end else begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: requester %0d got no ready, required ready within 50 cycles", id);
        end
        drive(id, 1'b0, a, b, op);
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [31:0] t4_res [8] = '{32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'h0000_0000, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000};
    logic [3:0]  t4_flg [8] = '{4'b1100, 4'b1010, 4'b0100, 4'b0100,
                                4'b0010, 4'b0100, 4'b0000, 4'b0010};

    initial begin
        logic [15:0] ops_before;
        logic        bad;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_outputs", {rsp_valid, rsp_id, rsp_result, rsp_flags, ops_done},
              {1'b0, 1'b0, 32'd0, 4'd0, 16'd0});
        check("reset_alu_regs", {alu_a, alu_b, alu_op}, '0);
        reset = 1'b0;

        // 1: single request, ready for one cycle, response two cycles after ready
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h5, 32'h3, 3'b000);
        #1;
        check("t1_ready0", {req0_ready, req1_ready}, 2'b10);
        exp_q.push_back('{id: 1'b0, result: 32'h8, flags: 4'b0000});
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 32'h5, 32'h3, 3'b000);
        check("t1_ready_one_cycle", req0_ready, 1'b0);
        @(negedge clk);
        #1;
        check("t1_exec_state", {rsp_valid, alu_a, alu_b, alu_op}, {1'b0, 32'h5, 32'h3, 3'b000});
        @(negedge clk);
        #1;
        check("t1_rsp_valid_latency", rsp_valid, 1'b1);
        drain();
        check("t1_ops_done", ops_done, 16'd1);

        // 2: both requesters held after reset alternate 0,1,0,1
        do_reset();
        grant_log.delete();
        fork
            begin
                issue(1'b0, 32'd10, 32'd20, 3'd0, 32'h0000_001E, 4'b0000);
                issue(1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd2, 32'h00F0_00F0, 4'b0000);
            end
            begin
                issue(1'b1, 32'd3, 32'd5, 3'd1, 32'hFFFF_FFFE, 4'b0100);
                issue(1'b1, 32'd0, 32'd0, 3'd3, 32'h0000_0000, 4'b0010);
            end
        join
        drain();
        if (grant_log.size() == 4)
            check("t2_grant_order", {grant_log[0], grant_log[1], grant_log[2], grant_log[3]}, 4'b0101);
        else
            check("t2_grant_count", grant_log.size(), 4);
        check("t2_ops_done", ops_done, 16'd4);

        // 3: response held under backpressure for 10 cycles
        rsp_ready = 1'b0;
        ops_before = ops_done;
        issue(1'b0, 32'h0000_00FF, 32'h0000_0F0F, 3'd4, 32'h0000_0FF0, 4'b0000);
        for (int n = 0; n < 10 && !rsp_valid; n++) @(negedge clk);
        drive(1'b1, 1'b1, 32'd1, 32'd1, 3'd0);
        bad = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            #1;
            if (!rsp_valid || rsp_id !== 1'b0 || rsp_result !== 32'h0000_0FF0 || rsp_flags !== 4'b0000 ||
                req0_ready || req1_ready || ops_done !== ops_before)
                bad = 1'b1;
        end
        check("t3_stall_stable", bad, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'd1, 32'd1, 3'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        check("t3_ops_done_release", ops_done, ops_before + 16'd1);
        drain();

        // 4: all-ones operands through every opcode, plus a signed overflow
        for (int k = 0; k < 8; k++)
            issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'(k), t4_res[k], t4_flg[k]);
        issue(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 3'd0, 32'h8000_0000, 4'b0101);
        drain();
        check("t4_ops_done", ops_done, 16'd14);

        // 5: reset during EXEC discards the operation
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h1234_5678, 32'h1, 3'd0);
        #1;
        check("t5_accept", req1_ready, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 32'h1234_5678, 32'h1, 3'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t5_reset_outputs", {rsp_valid, rsp_id, rsp_result, rsp_flags, ops_done, alu_a, alu_b, alu_op}, '0);
        @(negedge clk);
        reset = 1'b0;
        bad = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) bad = 1'b1;
        end
        check("t5_no_rsp_after_reset", bad, 1'b0);
        grant_log.delete();
        fork
            issue(1'b0, 32'd7, 32'd7, 3'd1, 32'h0000_0000, 4'b1010);
            issue(1'b1, 32'd2, 32'd1, 3'd5, 32'h0000_0004, 4'b0000);
        join
        drain();
        if (grant_log.size() > 0)
            check("t5_first_tie_grant", grant_log[0], 1'b0);
        else
            check("t5_grant_count", grant_log.size(), 2);

        // 6: counter wraps from all ones to zero
        @(negedge clk);
        force dut.ops_done = 16'hFFFF;
        @(negedge clk);
        release dut.ops_done;
        @(negedge clk);
        #1;
        check("t6_preload", ops_done, 16'hFFFF);
        issue(1'b0, 32'd1, 32'd1, 3'd0, 32'h0000_0002, 4'b0000);
        drain();
        check("t6_wrap", ops_done, 16'h0000);

        check("no_dual_ready", dual_ready_errs, 0);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
